// File: rtl/qpd_pkg.sv
// Shared types and default constants for the quarter-period-delay trigger generator.
package qpd_pkg;

    localparam int unsigned NUM_CH_DEFAULT  = 4;
    localparam int unsigned DELAY_W_DEFAULT = 16;
    localparam int unsigned HOLDOFF_DEFAULT = 23000;
    localparam int unsigned PULSE_W_DEFAULT = 1;
    localparam int unsigned HOLD_W_DEFAULT  = 32;

    // Per-channel sequencing state.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DELAY = 2'd1,
        ST_HOLD  = 2'd2,
        ST_PULSE = 2'd3
    } qpd_state_e;

endpackage

// File: rtl/qpd_channel.sv
// One trigger channel: request latch, delay count, holdoff gate, pulse timer, overrun flag.
module qpd_channel
    import qpd_pkg::*;
#(
    parameter int unsigned DELAY_W = DELAY_W_DEFAULT,
    parameter int unsigned HOLDOFF = HOLDOFF_DEFAULT,
    parameter int unsigned PULSE_W = PULSE_W_DEFAULT,
    parameter int unsigned HOLD_W  = HOLD_W_DEFAULT
) (
    input  logic               sclock,
    input  logic               rst,
    input  logic               rt,
    input  logic [DELAY_W-1:0] delay,
    input  logic               periodic,
    input  logic               abort,
    output logic               trigger,
    output logic               busy,
    output logic               overrun
);

    localparam int unsigned       PCNT_W    = (PULSE_W > 1) ? $clog2(PULSE_W) : 1;
    localparam logic [PCNT_W-1:0] PCNT_LAST = PCNT_W'(PULSE_W - 1);
    localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(HOLDOFF);

    qpd_state_e         state_q, state_nx;
    logic [DELAY_W-1:0] dcnt_q, dcnt_nx;
    logic [DELAY_W-1:0] d_q, d_nx;
    logic               per_q, per_nx;
    logic [PCNT_W-1:0]  pcnt_q, pcnt_nx;
    logic [HOLD_W-1:0]  hold_q, hold_nx;
    logic [HOLD_W-1:0]  hold_inc;
    logic               hold_ok;
    logic               overrun_nx;

    // Saturating holdoff increment; the gate looks at the post-increment value so
    // consecutive pulse starts land exactly HOLDOFF cycles apart.
    always_comb begin
        hold_inc = (hold_q >= HOLD_MAX) ? hold_q : hold_q + HOLD_W'(1);
        hold_ok  = (hold_inc >= HOLD_MAX);
    end

    // Next-state and counter update logic.
    always_comb begin
        state_nx   = state_q;
        dcnt_nx    = dcnt_q;
        d_nx       = d_q;
        per_nx     = per_q;
        pcnt_nx    = pcnt_q;
        hold_nx    = hold_inc;
        overrun_nx = overrun;

        if (abort) begin
            state_nx = ST_IDLE;
        end else begin
            if (rt && (state_q != ST_IDLE)) begin
                overrun_nx = 1'b1;
            end
            unique case (state_q)
                ST_IDLE: begin
                    if (rt) begin
                        d_nx     = delay;
                        per_nx   = periodic;
                        dcnt_nx  = '0;
                        state_nx = ST_DELAY;
                    end
                end
                ST_DELAY: begin
                    if (dcnt_q == d_q) begin
                        if (hold_ok) begin
                            state_nx = ST_PULSE;
                            pcnt_nx  = '0;
                            hold_nx  = '0;
                        end else begin
                            state_nx = ST_HOLD;
                        end
                    end else begin
                        dcnt_nx = dcnt_q + DELAY_W'(1);
                    end
                end
                ST_HOLD: begin
                    if (hold_ok) begin
                        state_nx = ST_PULSE;
                        pcnt_nx  = '0;
                        hold_nx  = '0;
                    end
                end
                ST_PULSE: begin
                    if (pcnt_q == PCNT_LAST) begin
                        if (per_q) begin
                            state_nx = ST_DELAY;
                            dcnt_nx  = '0;
                        end else begin
                            state_nx = ST_IDLE;
                        end
                    end else begin
                        pcnt_nx = pcnt_q + PCNT_W'(1);
                    end
                end
                default: state_nx = ST_IDLE;
            endcase
        end
    end

    // State, counters and registered outputs.
    always_ff @(posedge sclock or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            dcnt_q  <= '0;
            d_q     <= '0;
            per_q   <= 1'b0;
            pcnt_q  <= '0;
            hold_q  <= HOLD_MAX;
            trigger <= 1'b0;
            busy    <= 1'b0;
            overrun <= 1'b0;
        end else begin
            state_q <= state_nx;
            dcnt_q  <= dcnt_nx;
            d_q     <= d_nx;
            per_q   <= per_nx;
            pcnt_q  <= pcnt_nx;
            hold_q  <= hold_nx;
            trigger <= (state_nx == ST_PULSE);
            busy    <= (state_nx != ST_IDLE);
            overrun <= overrun_nx;
        end
    end

endmodule

// File: rtl/qpd_trigger_gen.sv
// Multi-channel quarter-period-delay trigger generator: NUM_CH independent channels.
module qpd_trigger_gen
    import qpd_pkg::*;
#(
    parameter int unsigned NUM_CH  = NUM_CH_DEFAULT,
    parameter int unsigned DELAY_W = DELAY_W_DEFAULT,
    parameter int unsigned HOLDOFF = HOLDOFF_DEFAULT,
    parameter int unsigned PULSE_W = PULSE_W_DEFAULT,
    parameter int unsigned HOLD_W  = HOLD_W_DEFAULT
) (
    input  logic                      sclock,
    input  logic                      rst,
    input  logic [NUM_CH-1:0]         rt,
    input  logic [NUM_CH*DELAY_W-1:0] delay,
    input  logic [NUM_CH-1:0]         periodic,
    input  logic [NUM_CH-1:0]         abort,
    output logic [NUM_CH-1:0]         trigger,
    output logic [NUM_CH-1:0]         busy,
    output logic [NUM_CH-1:0]         overrun
);

    // One channel per request line; each gets its own slice of the delay bus.
    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        qpd_channel #(
            .DELAY_W (DELAY_W),
            .HOLDOFF (HOLDOFF),
            .PULSE_W (PULSE_W),
            .HOLD_W  (HOLD_W)
        ) u_ch (
            .sclock   (sclock),
            .rst      (rst),
            .rt       (rt[i]),
            .delay    (delay[i*DELAY_W +: DELAY_W]),
            .periodic (periodic[i]),
            .abort    (abort[i]),
            .trigger  (trigger[i]),
            .busy     (busy[i]),
            .overrun  (overrun[i])
        );
    end

endmodule

// File: tb/tb_qpd_trigger_gen.sv
// Bench for qpd_trigger_gen: directed vector table, hand sequences, randomized model compare.
`timescale 1ns/1ps
module tb_qpd_trigger_gen;

    localparam int unsigned NUM_CH  = 2;
    localparam int unsigned DELAY_W = 8;
    localparam int unsigned HOLDOFF = 10;
    localparam int unsigned PULSE_W = 2;
    localparam int unsigned HOLD_W  = 32;

    logic                      sclock;
    logic                      rst;
    logic [NUM_CH-1:0]         rt;
    logic [NUM_CH*DELAY_W-1:0] delay;
    logic [NUM_CH-1:0]         periodic;
    logic [NUM_CH-1:0]         abort;
    logic [NUM_CH-1:0]         trigger;
    logic [NUM_CH-1:0]         busy;
    logic [NUM_CH-1:0]         overrun;

    qpd_trigger_gen #(
        .NUM_CH (NUM_CH), .DELAY_W (DELAY_W), .HOLDOFF (HOLDOFF),
        .PULSE_W (PULSE_W), .HOLD_W (HOLD_W)
    ) dut (
        .sclock (sclock), .rst (rst), .rt (rt), .delay (delay),
        .periodic (periodic), .abort (abort),
        .trigger (trigger), .busy (busy), .overrun (overrun)
    );

    initial sclock = 1'b0;
    always #5 sclock = ~sclock;

    int n_pass   = 0;
    int n_checks = 0;
    longint cyc  = 0;

    // Timeline reference model: each channel is a scheduled pulse start time.
    logic [NUM_CH-1:0] m_act, m_per, m_ovr, m_have_last, m_trig, m_busy;
    longint m_st[NUM_CH];
    longint m_last[NUM_CH];
    longint m_d[NUM_CH];

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    endtask

    function automatic void model_reset();
        m_act = '0; m_per = '0; m_ovr = '0; m_have_last = '0;
        m_trig = '0; m_busy = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            m_st[c] = 0; m_last[c] = 0; m_d[c] = 0;
        end
    endfunction

    // Advance the model across the edge numbered cyc, using the inputs present at that edge.
    function automatic void model_edge();
        for (int c = 0; c < NUM_CH; c++) begin
            logic was_busy;
            longint nxt;
            was_busy = m_act[c];
            if (abort[c]) begin
                m_act[c] = 1'b0;
            end else begin
                if (rt[c] && was_busy) m_ovr[c] = 1'b1;
                if (m_act[c] && cyc == m_st[c] + longint'(PULSE_W)) begin
                    if (m_per[c]) begin
                        nxt = m_st[c] + longint'(PULSE_W) + m_d[c] + 1;
                        if (m_st[c] + longint'(HOLDOFF) > nxt) nxt = m_st[c] + longint'(HOLDOFF);
                        m_st[c] = nxt;
                    end else begin
                        m_act[c] = 1'b0;
                    end
                end
                if (rt[c] && !was_busy) begin
                    m_act[c] = 1'b1;
                    m_per[c] = periodic[c];
                    m_d[c]   = longint'(delay[c*DELAY_W +: DELAY_W]);
                    nxt      = cyc + m_d[c] + 1;
                    if (m_have_last[c] && m_last[c] + longint'(HOLDOFF) > nxt)
                        nxt = m_last[c] + longint'(HOLDOFF);
                    m_st[c] = nxt;
                end
            end
            if (m_act[c] && cyc == m_st[c]) begin
                m_last[c] = cyc;
                m_have_last[c] = 1'b1;
            end
            m_trig[c] = m_act[c] && (cyc >= m_st[c]) && (cyc < m_st[c] + longint'(PULSE_W));
            m_busy[c] = m_act[c];
        end
    endfunction

    // Drive one cycle of inputs, clock it, then compare against the model.
    task automatic tick(input logic [1:0] r, input logic [1:0] a, input logic [1:0] p,
                        input logic [7:0] d0, input logic [7:0] d1);
        rt = r; abort = a; periodic = p; delay = {d1, d0};
        @(posedge sclock);
        cyc++;
        model_edge();
        #1;
        check("model", int'({trigger, busy, overrun}), int'({m_trig, m_busy, m_ovr}));
    endtask

    task automatic do_reset();
        rt = '0; abort = '0; periodic = '0; delay = '0;
        rst = 1'b1;
        #1;
        check("reset_trigger", int'(trigger), 0);
        check("reset_busy", int'(busy), 0);
        check("reset_overrun", int'(overrun), 0);
        repeat (2) @(posedge sclock);
        #1 rst = 1'b0;
        model_reset();
        cyc = 0;
    endtask

    typedef struct {
        logic [1:0] rt;
        logic [7:0] d0;
        logic [1:0] exp_trig;
        logic [1:0] exp_busy;
    } vec_t;

    vec_t vt[10];
    int   starts[$];
    logic prev;

    initial begin
        // One-shot D=5 on channel 0; delay changes after acceptance must be ignored.
        vt[0] = '{2'b01, 8'd5, 2'b00, 2'b01};
        for (int i = 1; i <= 5; i++) vt[i] = '{2'b00, 8'd0, 2'b00, 2'b01};
        vt[6] = '{2'b00, 8'd0, 2'b01, 2'b01};
        vt[7] = '{2'b00, 8'd0, 2'b01, 2'b01};
        vt[8] = '{2'b00, 8'd0, 2'b00, 2'b00};
        vt[9] = '{2'b00, 8'd0, 2'b00, 2'b00};

        do_reset();
        for (int i = 0; i < 10; i++) begin
            tick(vt[i].rt, 2'b00, 2'b00, vt[i].d0, 8'd0);
            check("vec_trigger", int'(trigger), int'(vt[i].exp_trig));
            check("vec_busy", int'(busy), int'(vt[i].exp_busy));
        end

        // Periodic D=2: starts at +3, +13, +23 (holdoff-limited), abort at +25.
        do_reset();
        tick(2'b01, 2'b00, 2'b01, 8'd2, 8'd0);
        for (int k = 1; k <= 24; k++) begin
            tick(2'b00, 2'b00, 2'b00, 8'd0, 8'd0);
            check("per_trigger", int'(trigger[0]),
                  int'((k == 3) || (k == 4) || (k == 13) || (k == 14) || (k == 23) || (k == 24)));
        end
        tick(2'b00, 2'b01, 2'b00, 8'd0, 8'd0);
        check("per_abort_trigger", int'(trigger[0]), 0);
        check("per_abort_busy", int'(busy[0]), 0);
        tick(2'b00, 2'b00, 2'b00, 8'd0, 8'd0);
        check("per_abort_idle", int'(busy[0]), 0);

        // Periodic D=20: spacing is D+1+PULSE_W = 23, never holdoff-limited.
        do_reset();
        tick(2'b01, 2'b00, 2'b01, 8'd20, 8'd0);
        starts.delete(); prev = 1'b0;
        for (int k = 1; k <= 70; k++) begin
            tick(2'b00, 2'b00, 2'b00, 8'd0, 8'd0);
            if (trigger[0] && !prev) starts.push_back(k);
            prev = trigger[0];
        end
        check("long_count", starts.size(), 3);
        if (starts.size() == 3) begin
            check("long_first", starts[0], 21);
            check("long_gap1", starts[1] - starts[0], 23);
            check("long_gap2", starts[2] - starts[1], 23);
        end
        tick(2'b00, 2'b01, 2'b00, 8'd0, 8'd0);

        // One-shot D=0 then a second request 4 cycles later: held off to +11.
        do_reset();
        tick(2'b01, 2'b00, 2'b00, 8'd0, 8'd0);
        starts.delete(); prev = trigger[0];
        if (trigger[0]) starts.push_back(0);
        for (int k = 1; k <= 14; k++) begin
            tick((k == 4) ? 2'b01 : 2'b00, 2'b00, 2'b00, 8'd0, 8'd0);
            if (trigger[0] && !prev) starts.push_back(k);
            prev = trigger[0];
            if (k == 9) begin
                check("hold_busy", int'(busy[0]), 1);
                check("hold_trigger", int'(trigger[0]), 0);
            end
        end
        check("hold_count", starts.size(), 2);
        if (starts.size() == 2) begin
            check("hold_first", starts[0], 1);
            check("hold_second", starts[1], 11);
        end
        check("hold_overrun", int'(overrun[0]), 0);

        // Overrun on channel 1, then rt+abort together on idle channel 0.
        do_reset();
        tick(2'b10, 2'b00, 2'b00, 8'd0, 8'd6);
        starts.delete(); prev = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            tick((k == 2) ? 2'b10 : 2'b00, 2'b00, 2'b00, 8'd0, 8'd1);
            if (k == 2) check("ovr_set", int'(overrun[1]), 1);
            if (trigger[1] && !prev) starts.push_back(k);
            prev = trigger[1];
        end
        check("ovr_timing_count", starts.size(), 1);
        if (starts.size() == 1) check("ovr_timing", starts[0], 7);
        tick(2'b01, 2'b01, 2'b00, 8'd3, 8'd0);
        check("ra_busy", int'(busy[0]), 0);
        check("ra_overrun", int'(overrun[0]), 0);
        for (int k = 0; k < 8; k++) tick(2'b00, 2'b00, 2'b00, 8'd0, 8'd0);
        check("ra_trigger", int'(trigger[0]), 0);
        check("ovr_sticky", int'(overrun[1]), 1);

        // Reset mid-pulse truncates; holdoff preset lets the next request fire unblocked.
        do_reset();
        tick(2'b01, 2'b00, 2'b00, 8'd1, 8'd0);
        tick(2'b00, 2'b00, 2'b00, 8'd0, 8'd0);
        tick(2'b00, 2'b00, 2'b00, 8'd0, 8'd0);
        check("mid_pulse_high", int'(trigger[0]), 1);
        do_reset();
        tick(2'b01, 2'b00, 2'b00, 8'd3, 8'd0);
        starts.delete(); prev = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            tick(2'b00, 2'b00, 2'b00, 8'd0, 8'd0);
            if (trigger[0] && !prev) starts.push_back(k);
            prev = trigger[0];
        end
        check("post_rst_count", starts.size(), 1);
        if (starts.size() == 1) check("post_rst_start", starts[0], 4);

        // Randomized traffic on both channels against the model.
        do_reset();
        for (int k = 0; k < 4000; k++) begin
            logic [1:0] r, a, p;
            logic [7:0] d0, d1;
            for (int c = 0; c < 2; c++) begin
                r[c] = ($urandom % 10) == 0;
                a[c] = ($urandom % 45) == 0;
                p[c] = $urandom % 2;
            end
            d0 = 8'(($urandom % 8 == 0) ? $urandom % 40 : $urandom % 12);
            d1 = 8'(($urandom % 8 == 0) ? $urandom % 40 : $urandom % 12);
            tick(r, a, p, d0, d1);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/qpd_trigger_gen.md
Name: qpd_trigger_gen

Overview:
Multi-channel, parametrised quarter-period-delay trigger generator.
Each channel accepts a trigger request with a programmable delay. It emits a trigger pulse of configurable width once the delay has elapsed and a minimum holdoff since that channel's previous trigger is satisfied.
Supports one-shot and periodic (free-running re-trigger) modes, per-channel abort, and overrun reporting.
Sits between the C-server-driven control registers and the measurement front end. It replaces the single-channel 8-bit quarter-period delay block.

Parameters:
NUM_CH, 4, number of independent trigger channels
DELAY_W, 16, width of each channel's delay value in sclock cycles
HOLDOFF, 23000, minimum sclock cycles from one pulse start to the next pulse start on the same channel
PULSE_W, 1, trigger pulse width in sclock cycles (>=1)
HOLD_W, 32, width of holdoff counter (must hold HOLDOFF)

Ports:
sclock  input  1  system clock, all logic on rising edge
rst  input  1  asynchronous, active-high reset
rt  input  NUM_CH  per-channel request strobe, level-sampled each cycle
delay  input  NUM_CH*DELAY_W  per-channel delay; channel i at bits [i*DELAY_W +: DELAY_W]
periodic  input  NUM_CH  per-channel mode, latched at request acceptance: 0 one-shot, 1 periodic
abort  input  NUM_CH  per-channel abort strobe
trigger  output  NUM_CH  per-channel trigger pulse
busy  output  NUM_CH  channel not in IDLE
overrun  output  NUM_CH  sticky: request arrived while channel busy; cleared only by rst

Behaviour:
- Reset (async assert, sync-safe deassert):
  - trigger=0, busy=0, overrun=0, all channels IDLE, latched delay=0, latched mode=0.
  - Holdoff counter preset to HOLDOFF, so the first trigger after reset is never blocked.
- Channels are fully independent; there is no cross-channel arbitration.
- Per-channel FSM states: IDLE, DELAY, HOLD, PULSE.
- IDLE:
  - rt[i]=1 and abort[i]=0 at edge N → latch delay D and mode, clear delay counter, go to DELAY.
  - busy goes high after edge N.
- DELAY:
  - Counter increments each cycle.
  - When counter==D: if holdoff counter >= HOLDOFF go to PULSE, else go to HOLD.
  - With holdoff satisfied, trigger rises at edge N+D+1. D=0 gives trigger at N+1.
- HOLD:
  - Wait until holdoff counter >= HOLDOFF, then go to PULSE on that edge.
- PULSE:
  - trigger=1 for exactly PULSE_W cycles.
  - Holdoff counter cleared on the entry edge.
  - On exit: one-shot → IDLE; periodic → DELAY with counter cleared and the same latched D.
  - Periodic pulse-start to pulse-start interval = max(D+1+PULSE_W, HOLDOFF) cycles.
- Holdoff counter:
  - Per-channel, increments every cycle, saturates at HOLDOFF (no wrap).
- Input latching:
  - delay/periodic inputs are ignored while busy; changes take effect only on the next accepted request.
- rt while busy:
  - Request is dropped and overrun[i] is set on the next edge.
  - rt held high continuously does not set overrun on the acceptance edge itself.
  - rt still high on the first busy cycle is treated as a new request and sets overrun.
  - Requesters must pulse rt for one cycle.
- abort[i]=1 in any state:
  - Next state IDLE; trigger[i]=0 and busy[i]=0 after that edge, even mid-pulse.
  - Holdoff counter is not cleared by abort.
- abort and rt in the same cycle: abort wins, the request is dropped, overrun is not set.
- Request in the same cycle a one-shot PULSE completes: the channel is still busy, so the request is dropped and overrun is set.
- Reset mid-operation: immediate return to reset values; an in-flight pulse is truncated.
- Arithmetic:
  - Delay counter is DELAY_W bits and never exceeds D, so no wrap.
  - Holdoff compare is unsigned, HOLD_W bits.

Decomposition:
- Package qpd_pkg: channel state enum (IDLE, DELAY, HOLD, PULSE), default parameter constants (HOLDOFF_DEFAULT=23000, DELAY_W_DEFAULT=16).
- Sub-module qpd_channel: one FSM plus delay, pulse and holdoff counters, overrun flag.
- Top level generates NUM_CH instances and slices the delay bus.

Test Plan:
Bench parameters for all cases: NUM_CH=2, DELAY_W=8, HOLDOFF=10, PULSE_W=2.
- Reset, then 1-cycle rt[0] at edge N with delay0=5, periodic=0 → trigger[0] high at N+6 and N+7; busy[0] high N+1..N+7; trigger[1] stays 0.
- Periodic, delay0=2, rt pulse at N → pulses start at N+3, N+13, N+23 (holdoff-limited to 10); abort at N+25 → trigger=0 and busy=0 from N+26.
- Periodic, delay0=20 → pulse starts spaced exactly 23 cycles apart (D+1+PULSE_W); HOLD state never entered.
- One-shot delay0=0 at N, then second request at N+4 → second pulse starts at N+1+10=N+11 (HOLD observed); overrun stays 0.
- rt[1] pulsed during channel 1 DELAY → overrun[1]=1, sticky until rst; pulse timing of the original request unchanged; simultaneous rt[0]/abort[0] in IDLE → no activity, overrun[0]=0.
- Assert rst mid-PULSE → trigger drops immediately; after release, a new request with delay0=3 fires at N+4 (holdoff preset, not blocked).
